uart_tx_arbiter: RTL and testbench

- Shares one uart_txd transmitter between NUM_REQ byte requesters using round-robin arbitration with packet locking.
- Drives the transmitter's d/ena inputs and watches its ready output.
- Generates the single-cycle rising edge on ena that the transmitter edge-detects, and sequences one byte per transmitter frame.
- Sits between protocol/formatter blocks and uart_txd.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART TX arbiter.
// The master modport is the arbiter; slave is the environment (requesters + uart_txd).
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ack;
  logic [NUM_REQ-1:0]      grant;
  logic [7:0]              tx_d;
  logic                    tx_ena;
  logic                    tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, grant, tx_d, tx_ena
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, grant, tx_d, tx_ena
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_txd among NUM_REQ byte
// requesters; issues one ena strobe per byte and follows the transmitter's ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus,
  output logic              busy,
  output logic              err_timeout
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t             state, state_n;
  logic               lock, lock_n, last_q, last_n, err_n, busy_n, ena_n, found;
  logic [PW-1:0]      rr_ptr, rr_n, owner, owner_n, win, owner_inc;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NUM_REQ-1:0] cand, grant_n, ack_n;
  logic [7:0]         d_n;

  // While locked the grant vector masks the candidates down to the owner.
  assign cand      = lock ? (bus.req_valid & bus.grant) : bus.req_valid;
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  always_comb begin : arb
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    lock_n  = lock;
    last_n  = last_q;
    rr_n    = rr_ptr;
    owner_n = owner;
    cnt_n   = cnt;
    grant_n = bus.grant;
    ack_n   = '0;
    d_n     = bus.tx_d;
    ena_n   = 1'b0;
    err_n   = err_timeout;
    case (state)
      IDLE: if (bus.tx_ready && found) begin
        state_n      = STROBE;
        d_n          = bus.req_data[win];
        ack_n[win]   = 1'b1;
        grant_n      = '0;
        grant_n[win] = 1'b1;
        last_n       = bus.req_last[win];
        lock_n       = 1'b1;
        owner_n      = win;
      end
      // ena is registered, so it is high during the first WAIT_LOW cycle.
      STROBE: begin
        ena_n   = 1'b1;
        cnt_n   = '0;
        state_n = WAIT_LOW;
      end
      WAIT_LOW: if (!bus.tx_ready) begin
        state_n = WAIT_HIGH;
      end else if (cnt == CNT_MAX) begin
        err_n   = 1'b1;
        lock_n  = 1'b0;
        grant_n = '0;
        state_n = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      WAIT_HIGH: if (bus.tx_ready) begin
        state_n = IDLE;
        if (last_q) begin
          lock_n  = 1'b0;
          grant_n = '0;
          rr_n    = owner_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lock        <= 1'b0;
      last_q      <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      bus.grant   <= '0;
      bus.req_ack <= '0;
      bus.tx_d    <= 8'h00;
      bus.tx_ena  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      lock        <= lock_n;
      last_q      <= last_n;
      rr_ptr      <= rr_n;
      owner       <= owner_n;
      cnt         <= cnt_n;
      bus.grant   <= grant_n;
      bus.req_ack <= ack_n;
      bus.tx_d    <= d_n;
      bus.tx_ena  <= ena_n;
      busy        <= busy_n;
      err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a behavioural uart_txd
// ready model and a packet-level round-robin/lock reference.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;

  typedef struct {logic [7:0] d; logic last;} item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err_timeout;
  logic [1:0] mode = 2'd0;   // 0: transmitter model, 1: ready forced low, 2: ready forced high
  logic model_rdy;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign bus.tx_ready = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : model_rdy;

  // Transmitter: each ena pulse seen while idle starts one frame of flen cycles.
  int frames = 0;
  int tx_cnt;
  int flen = 4;
  logic [7:0] cap;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_rdy <= 1'b1;
      tx_cnt    <= 0;
    end else if (bus.tx_ena && tx_cnt == 0) begin
      model_rdy <= 1'b0;
      tx_cnt    <= flen;
      frames    <= frames + 1;
      cap       <= bus.tx_d;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) model_rdy <= 1'b1;
    end
  end

  int total = 0, bad = 0;
  item_t q [N][$];
  logic [N-1:0] gap = '0;
  logic [N-1:0] prev_valid = '0, prev_last = '0;
  logic [7:0]   prev_data [N];
  int  acc_log [$];
  int  m_ptr = 0, m_ptr_save = 0, m_owner = 0;
  bit  m_lock = 0;
  logic [7:0] m_cur = 8'h00;
  int  ena_cnt = 0, low_run = 0;
  bit  ena_prev = 0, seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec-level winner: owner only while locked, else first valid at/after pointer.
  function automatic int pick(input logic [N-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input logic last);
    item_t it;
    it.d = d;
    it.last = last;
    q[i].push_back(it);
  endtask

  task automatic step();
    int w;
    logic [N-1:0] oh, v, l;
    logic [N-1:0][7:0] dd;
    @(negedge clk);
    if (!rst_n) begin
      ena_prev = 0; low_run = 0; seen = 0;
    end else begin
      if (bus.tx_ena) begin
        ena_cnt++;
        check("ena_back_to_back", 32'(ena_prev), 0);
        if (seen) check("ena_low_gap_ge2", 32'(low_run >= 2), 1);
        seen = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
      ena_prev = bus.tx_ena;
      if (bus.req_ack != '0) begin
        w = pick(prev_valid);
        check("ack_has_winner", 32'(w >= 0), 1);
        if (w >= 0) begin
          oh = '0;
          oh[w] = 1'b1;
          check("req_ack_onehot", 32'(bus.req_ack), 32'(oh));
          check("grant_onehot", 32'(bus.grant), 32'(oh));
          check("tx_d_at_ack", 32'(bus.tx_d), 32'(prev_data[w]));
          acc_log.push_back(w);
          m_ptr_save = m_ptr;
          m_cur = prev_data[w];
          if (prev_last[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
          else begin m_lock = 1; m_owner = w; end
          if (q[w].size() > 0) void'(q[w].pop_front());
        end
      end
      check("tx_d_hold", 32'(bus.tx_d), 32'(m_cur));
    end
    v = '0; l = '0; dd = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && !gap[i]) begin
        v[i] = 1'b1; dd[i] = q[i][0].d; l[i] = q[i][0].last;
      end
      prev_data[i] = dd[i];
    end
    prev_valid = v;
    prev_last = l;
    bus.req_valid = v;
    bus.req_data = dd;
    bus.req_last = l;
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int start;
    start = acc_log.size();
    for (int c = 0; c < budget && acc_log.size() < start + n; c++) step();
    check(tag, 32'(acc_log.size() - start), 32'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (!busy) begin ok = 1; break; end
    end
    check(tag, 32'(ok), 1);
  endtask

  initial begin
    int base, n_rand, len, r;
    bit hit;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    step(); step();
    check("rst_tx_ena", 32'(bus.tx_ena), 0);
    check("rst_tx_d", 32'(bus.tx_d), 0);
    check("rst_req_ack", 32'(bus.req_ack), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);

    // tx_ready low after reset: no accept until it rises; then single byte
    mode = 2'd1;
    rst_n = 1'b1;
    push(2, 8'hA5, 1'b1);
    repeat (6) step();
    check("no_ack_ready_low", 32'(acc_log.size()), 0);
    check("idle_ready_low", 32'(busy), 0);
    mode = 2'd0;
    step();
    check("single_ack", 32'(bus.req_ack), 32'b0100);
    check("single_grant", 32'(bus.grant), 32'b0100);
    check("single_ena_not_yet", 32'(bus.tx_ena), 0);
    step();
    check("single_ena", 32'(bus.tx_ena), 1);
    check("single_ack_one_cycle", 32'(bus.req_ack), 0);
    wait_idle("single_idle", 200);
    check("single_grant_clear", 32'(bus.grant), 0);
    check("single_frame_byte", 32'(cap), 32'hA5);
    check("single_frames", 32'(frames), 1);

    // reset during WAIT_HIGH
    flen = 6;
    push(0, 8'h3C, 1'b0);
    wait_acks("rstmid_ack", 1, 20);
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy && !bus.tx_ready) begin hit = 1; break; end
    end
    check("rstmid_reach_wait", 32'(hit), 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx_ena", 32'(bus.tx_ena), 0);
    check("rstmid_grant", 32'(bus.grant), 0);
    check("rstmid_req_ack", 32'(bus.req_ack), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_err", 32'(err_timeout), 0);
    for (int i = 0; i < N; i++) q[i].delete();
    m_lock = 0; m_ptr = 0; m_cur = 8'h00;
    mode = 2'd1;
    step(); step();
    rst_n = 1'b1;
    // round robin among 0,1,3 with continuous traffic
    for (int k = 0; k < 2; k++) begin
      push(0, 8'h10 + 8'(k), 1'b1);
      push(1, 8'h20 + 8'(k), 1'b1);
      push(3, 8'h30 + 8'(k), 1'b1);
    end
    base = acc_log.size();
    repeat (4) step();
    check("rstmid_no_ack_ready_low", 32'(acc_log.size() - base), 0);
    mode = 2'd0;
    flen = 3;
    wait_acks("rr_acks", 6, 400);
    for (int k = 0; k < 6; k++) begin
      r = (k % 3 == 2) ? 3 : (k % 3);
      if (base + k < acc_log.size()) check("rr_order", 32'(acc_log[base + k]), 32'(r));
    end
    wait_idle("rr_idle", 200);

    // packet lock: requester 1 owns the link across a valid gap
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    base = acc_log.size();
    wait_acks("lock_first", 1, 20);
    gap[1] = 1'b1;
    push(0, 8'h51, 1'b1); push(0, 8'h52, 1'b1);
    repeat (30) step();
    check("lock_hold_during_gap", 32'(acc_log.size() - base), 1);
    gap[1] = 1'b0;
    wait_acks("lock_rest", 2, 200);
    wait_acks("lock_after", 1, 200);
    for (int k = 0; k < 3; k++)
      if (base + k < acc_log.size()) check("lock_owner", 32'(acc_log[base + k]), 1);
    if (base + 3 < acc_log.size()) check("lock_release_next", 32'(acc_log[base + 3]), 0);
    wait_acks("lock_drain", 1, 200);
    wait_idle("lock_idle", 200);

    // timeout: ready never falls
    mode = 2'd2;
    push(2, 8'h5A, 1'b1);
    wait_acks("to_ack", 1, 20);
    repeat (4) step();
    check("to_err_not_yet", 32'(err_timeout), 0);
    check("to_grant_held", 32'(bus.grant), 32'b0100);
    step();
    check("to_err", 32'(err_timeout), 1);
    check("to_grant_clear", 32'(bus.grant), 0);
    check("to_busy", 32'(busy), 0);
    m_ptr = m_ptr_save;
    m_lock = 0;
    mode = 2'd0;
    push(3, 8'h77, 1'b1);
    base = acc_log.size();
    wait_acks("to_next_ack", 1, 100);
    if (base < acc_log.size()) check("to_next_who", 32'(acc_log[base]), 3);
    wait_idle("to_next_idle", 200);
    check("to_err_sticky", 32'(err_timeout), 1);

    // randomized packets, gaps and frame lengths
    n_rand = 0;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, N - 1);
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        push(r, 8'($urandom), b == len - 1);
        n_rand++;
      end
    end
    base = acc_log.size();
    for (int c = 0; c < 20000; c++) begin
      for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 7) == 0);
      flen = $urandom_range(1, 12);
      step();
      if (all_empty() && !busy) break;
    end
    gap = '0;
    check("rand_all_served", 32'(acc_log.size() - base), 32'(n_rand));
    wait_idle("rand_idle", 200);
    check("frames_per_strobe", 32'(frames), 32'(ena_cnt));
    check("strobes_per_ack", 32'(ena_cnt), 32'(acc_log.size()));
    check("final_err_sticky", 32'(err_timeout), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
